watch_edit_ctrl: RTL

- Time-set controller for the watch datapath (sec/min/hour counters).
- While edit mode is enabled it owns a digit cursor, converts up/down buttons into single-cycle field load commands, and adds press-and-hold auto-repeat.
- Provides a blink strobe for the display and a run-freeze flag for the msec counter.
- Sits between the debounced buttons and the time counters; the counters only apply o_load and no longer do their own edit arithmetic.

---
 rtl/watch_edit_ctrl_if.sv | 31 +++
 rtl/watch_edit_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/watch_edit_ctrl_if.sv
// Button/tick inputs and field-load outputs between the debounced front panel,
// the edit controller and the watch time counters.
interface watch_edit_ctrl_if;
  logic       i_edit_en;
  logic       i_tick_100hz;
  logic       i_up;
  logic       i_down;
  logic       i_left;
  logic       i_right;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic [2:0] o_cursor;
  logic       o_load;
  logic [1:0] o_ld_field;
  logic [5:0] o_ld_value;
  logic       o_blink;
  logic       o_freeze;

  modport master (
    output i_edit_en, i_tick_100hz, i_up, i_down, i_left, i_right,
    output i_sec, i_min, i_hour,
    input  o_cursor, o_load, o_ld_field, o_ld_value, o_blink, o_freeze
  );

  modport slave (
    input  i_edit_en, i_tick_100hz, i_up, i_down, i_left, i_right,
    input  i_sec, i_min, i_hour,
    output o_cursor, o_load, o_ld_field, o_ld_value, o_blink, o_freeze
  );
endinterface

// File: rtl/watch_edit_ctrl.sv
// Time-set controller: digit cursor, up/down field loads with press-and-hold
// auto-repeat, display blink phase and msec-counter freeze.
module watch_edit_ctrl #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int BLINK_HALF   = 50
) (
  input  logic               clk,
  input  logic               rst,
  watch_edit_ctrl_if.slave   bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EDIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RPT  = 2'd3;
  localparam int CW = 16;

  logic [1:0]    state_q, state_d;
  logic [3:0]    btn_prev_q, btn_prev_d;
  logic          dir_up_q, dir_up_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [2:0]    cursor_q, cursor_d;
  logic          load_q, load_d;
  logic [1:0]    ld_field_q, ld_field_d;
  logic [5:0]    ld_value_q, ld_value_d;

  logic          up_press, down_press, left_press, right_press;
  logic          load_evt, load_up, held_ok;
  logic [CW-1:0] hold_limit;
  logic [1:0]    field;
  logic [6:0]    cur_val, max_val, step_val, clamp_val, sum_val;
  logic [5:0]    new_val;

  assign up_press    = bus.i_up    & ~btn_prev_q[0];
  assign down_press  = bus.i_down  & ~btn_prev_q[1];
  assign left_press  = bus.i_left  & ~btn_prev_q[2];
  assign right_press = bus.i_right & ~btn_prev_q[3];
  assign btn_prev_d  = {bus.i_right, bus.i_left, bus.i_down, bus.i_up};

  // Field arithmetic: clamp an out-of-range reading, then step with wrap.
  always_comb begin
    field    = cursor_q[2:1];
    step_val = cursor_q[0] ? 7'd10 : 7'd1;
    case (field)
      2'd0:    begin cur_val = {1'b0, bus.i_sec}; max_val = 7'd60; end
      2'd1:    begin cur_val = {1'b0, bus.i_min}; max_val = 7'd60; end
      default: begin cur_val = {2'b0, bus.i_hour}; max_val = 7'd24; end
    endcase
    clamp_val = (cur_val >= max_val) ? max_val - 7'd1 : cur_val;
    sum_val   = clamp_val + step_val;
    if (load_up)
      new_val = (sum_val >= max_val) ? 6'(sum_val - max_val) : 6'(sum_val);
    else
      new_val = (clamp_val < step_val) ? 6'(clamp_val + max_val - step_val)
                                       : 6'(clamp_val - step_val);
  end

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    cursor_d    = cursor_q;
    load_evt    = 1'b0;
    load_up     = dir_up_q;
    held_ok     = dir_up_q ? (bus.i_up & ~bus.i_down) : (bus.i_down & ~bus.i_up);
    hold_limit  = (state_q == ST_HOLD) ? CW'(REPEAT_DELAY) : CW'(REPEAT_RATE);

    if (state_q != ST_IDLE && bus.i_tick_100hz) begin
      if (blink_cnt_q + CW'(1) == CW'(BLINK_HALF)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_edit_en) begin
          state_d     = ST_EDIT;
          cursor_d    = 3'd0;
          blink_cnt_d = '0;
          blink_d     = 1'b0;
        end
      end
      ST_EDIT: begin
        if (up_press && !bus.i_down) begin
          load_evt = 1'b1; load_up = 1'b1; dir_up_d = 1'b1;
          state_d = ST_HOLD; hold_cnt_d = '0;
        end else if (down_press && !bus.i_up) begin
          load_evt = 1'b1; load_up = 1'b0; dir_up_d = 1'b0;
          state_d = ST_HOLD; hold_cnt_d = '0;
        end else if (!bus.i_up && !bus.i_down && left_press && !right_press) begin
          cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
        end else if (!bus.i_up && !bus.i_down && right_press && !left_press) begin
          cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
        end
      end
      default: begin
        // HOLD and RPT share exit rules; only the tick limit differs.
        if (!held_ok) begin
          state_d = ST_EDIT;
        end else if (bus.i_tick_100hz) begin
          if (hold_cnt_q + CW'(1) == hold_limit) begin
            load_evt   = 1'b1;
            state_d    = ST_RPT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end
      end
    endcase

    if (state_q != ST_IDLE && !bus.i_edit_en) begin
      state_d     = ST_IDLE;
      load_evt    = 1'b0;
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end

    load_d     = load_evt;
    ld_field_d = load_evt ? field   : ld_field_q;
    ld_value_d = load_evt ? new_val : ld_value_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      btn_prev_q  <= '0;
      dir_up_q    <= 1'b0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      cursor_q    <= '0;
      load_q      <= 1'b0;
      ld_field_q  <= '0;
      ld_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn_prev_d;
      dir_up_q    <= dir_up_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      cursor_q    <= cursor_d;
      load_q      <= load_d;
      ld_field_q  <= ld_field_d;
      ld_value_q  <= ld_value_d;
    end
  end

  assign bus.o_cursor   = cursor_q;
  assign bus.o_load     = load_q;
  assign bus.o_ld_field = ld_field_q;
  assign bus.o_ld_value = ld_value_q;
  assign bus.o_blink    = blink_q;
  assign bus.o_freeze   = (state_q != ST_IDLE);
endmodule
